// File: rtl/noc_pass_scheduler_if.sv
// ---------------------------------------------------------------------------
// noc_pass_scheduler_if
//   Handshake bundle between the layer sequencer and the engines it drives.
//   The engines are the filter, ifmap and psum index generators and the PE array.
//   master : sequencer side. It drives the start pulses and gen_await. It
//            receives the done pulses and glb_ready.
//   slave  : engine / global buffer side, with the directions reversed.
//   Signals
//     filt_start/ifmap_start/pe_start/psum_start : one-cycle start pulses
//     filt_done /ifmap_done /pe_done /psum_done  : one-cycle completion pulses
//     gen_await : stall to the active index generator
//     glb_ready : global buffer port can serve an access this cycle
// ---------------------------------------------------------------------------
interface noc_pass_scheduler_if;
    logic filt_start;
    logic ifmap_start;
    logic pe_start;
    logic psum_start;
    logic gen_await;
    logic filt_done;
    logic ifmap_done;
    logic pe_done;
    logic psum_done;
    logic glb_ready;

    modport master (
        output filt_start, ifmap_start, pe_start, psum_start, gen_await,
        input  filt_done, ifmap_done, pe_done, psum_done, glb_ready
    );

    modport slave (
        input  filt_start, ifmap_start, pe_start, psum_start, gen_await,
        output filt_done, ifmap_done, pe_done, psum_done, glb_ready
    );
endinterface

// File: rtl/noc_pass_scheduler.sv
// ---------------------------------------------------------------------------
// noc_pass_scheduler
//   Sequences one NoC layer as a series of passes. Each pass runs four phases
//   in order: filter load, ifmap load, PE compute and psum drain. The filter
//   load is skipped while the filters loaded earlier are still being reused.
//   Ports
//     clk, reset     : rising-edge clock, asynchronous active-high reset
//     start          : begin a layer; looked at only while idle
//     num_passes     : passes in the layer; latched at start
//     filt_reuse     : consecutive passes that share one filter load; 0 means 1
//     gen            : start/done handshakes, gen_await and glb_ready
//     busy           : high in every state except IDLE
//     done           : one-cycle pulse when the layer completes
//     pass_index     : current pass, 0-based; holds after the layer ends
//     phase          : debug code (IDLE 0, FILT 1, IFMAP 2, COMP 3, PSUM 4, DONE 5)
// ---------------------------------------------------------------------------
module noc_pass_scheduler #(
    parameter int PASS_WIDTH  = 8,
    parameter int REUSE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PASS_WIDTH-1:0]  num_passes,
    input  logic [REUSE_WIDTH-1:0] filt_reuse,
    noc_pass_scheduler_if.master   gen,
    output logic                   busy,
    output logic                   done,
    output logic [PASS_WIDTH-1:0]  pass_index,
    output logic [2:0]             phase
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILT_START,  S_FILT_WAIT,
        S_IFMAP_START, S_IFMAP_WAIT,
        S_COMP_START,  S_COMP_WAIT,
        S_PSUM_START,  S_PSUM_WAIT,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [PASS_WIDTH-1:0]  pass_q;
    logic [PASS_WIDTH-1:0]  num_passes_q;
    logic [REUSE_WIDTH-1:0] reuse_q;
    logic [REUSE_WIDTH-1:0] filt_reuse_q;
    logic                   filt_start_q;
    logic                   ifmap_start_q;
    logic                   pe_start_q;
    logic                   psum_start_q;
    logic                   done_q;

    // A reuse setting of 0 behaves like 1, so the wrap point is 0 in both cases.
    logic [REUSE_WIDTH-1:0] reuse_last;
    logic [REUSE_WIDTH-1:0] reuse_nxt;
    logic                   last_pass;

    assign reuse_last = (filt_reuse_q == '0) ? '0 : filt_reuse_q - REUSE_WIDTH'(1);
    assign reuse_nxt  = (reuse_q == reuse_last) ? '0 : reuse_q + REUSE_WIDTH'(1);
    assign last_pass  = (pass_q == num_passes_q - PASS_WIDTH'(1));

    // Each start pulse is registered when its START state is entered, so it lines
    // up with that state. A done input therefore never reaches a start output
    // through combinational logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pass_q        <= '0;
            num_passes_q  <= '0;
            reuse_q       <= '0;
            filt_reuse_q  <= '0;
            filt_start_q  <= 1'b0;
            ifmap_start_q <= 1'b0;
            pe_start_q    <= 1'b0;
            psum_start_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            filt_start_q  <= 1'b0;
            ifmap_start_q <= 1'b0;
            pe_start_q    <= 1'b0;
            psum_start_q  <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_passes_q <= num_passes;
                        filt_reuse_q <= filt_reuse;
                        pass_q       <= '0;
                        reuse_q      <= '0;
                        if (num_passes == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= S_FILT_START;
                            filt_start_q <= 1'b1;
                        end
                    end
                end
                // A nonzero reuse count means the filters are already loaded.
                S_FILT_START: begin
                    if (reuse_q == '0) begin
                        state_q <= S_FILT_WAIT;
                    end else begin
                        state_q       <= S_IFMAP_START;
                        ifmap_start_q <= 1'b1;
                    end
                end
                S_FILT_WAIT: begin
                    if (gen.filt_done) begin
                        state_q       <= S_IFMAP_START;
                        ifmap_start_q <= 1'b1;
                    end
                end
                S_IFMAP_START: state_q <= S_IFMAP_WAIT;
                S_IFMAP_WAIT: begin
                    if (gen.ifmap_done) begin
                        state_q    <= S_COMP_START;
                        pe_start_q <= 1'b1;
                    end
                end
                S_COMP_START: state_q <= S_COMP_WAIT;
                S_COMP_WAIT: begin
                    if (gen.pe_done) begin
                        state_q      <= S_PSUM_START;
                        psum_start_q <= 1'b1;
                    end
                end
                S_PSUM_START: state_q <= S_PSUM_WAIT;
                S_PSUM_WAIT: begin
                    if (gen.psum_done) begin
                        reuse_q <= reuse_nxt;
                        if (last_pass) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            pass_q       <= pass_q + PASS_WIDTH'(1);
                            state_q      <= S_FILT_START;
                            filt_start_q <= (reuse_nxt == '0);
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        phase = 3'd0;
        case (state_q)
            S_FILT_START,  S_FILT_WAIT:  phase = 3'd1;
            S_IFMAP_START, S_IFMAP_WAIT: phase = 3'd2;
            S_COMP_START,  S_COMP_WAIT:  phase = 3'd3;
            S_PSUM_START,  S_PSUM_WAIT:  phase = 3'd4;
            S_DONE:                      phase = 3'd5;
            default:                     phase = 3'd0;
        endcase
    end

    // The PE array does not touch the global buffer, so COMP is never stalled.
    assign gen.gen_await = !gen.glb_ready &&
                           (state_q == S_FILT_WAIT || state_q == S_IFMAP_WAIT ||
                            state_q == S_PSUM_WAIT);

    assign gen.filt_start  = filt_start_q;
    assign gen.ifmap_start = ifmap_start_q;
    assign gen.pe_start    = pe_start_q;
    assign gen.psum_start  = psum_start_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign pass_index      = pass_q;

endmodule

// File: tb/tb_noc_pass_scheduler.sv
// Scoreboard bench for noc_pass_scheduler. The stimulus pushes the expected pulse
// sequence for each layer, using one char per pulse: F filt, I ifmap, P pe, S psum,
// D done. A monitor pops an entry on every start/done pulse and compares it.
module tb_noc_pass_scheduler;
    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] num_passes;
    logic [3:0] filt_reuse;
    logic       busy;
    logic       done;
    logic [7:0] pass_index;
    logic [2:0] phase;
    logic       glb_ready;
    logic       stray_pe;
    logic [3:0] rdone;
    int         dly[4];
    int         rcnt[4];

    typedef struct {
        int kind;
        int pass;
    } ev_t;
    ev_t sb[$];

    int total = 0;
    int bad   = 0;

    noc_pass_scheduler_if bus ();

    assign bus.filt_done  = rdone[0];
    assign bus.ifmap_done = rdone[1];
    assign bus.pe_done    = rdone[2] | stray_pe;
    assign bus.psum_done  = rdone[3];
    assign bus.glb_ready  = glb_ready;

    noc_pass_scheduler #(.PASS_WIDTH(8), .REUSE_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_passes (num_passes),
        .filt_reuse (filt_reuse),
        .gen        (bus),
        .busy       (busy),
        .done       (done),
        .pass_index (pass_index),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected pass index: count the psum drains so far. Done reports the last pass.
    task automatic push_str(input string s);
        int  p;
        ev_t e;
        p = 0;
        for (int i = 0; i < s.len(); i++) begin
            e.kind = int'(s.getc(i));
            e.pass = (e.kind == "D") ? ((p == 0) ? 0 : p - 1) : p;
            sb.push_back(e);
            if (e.kind == "S") p++;
        end
    endtask

    // Engine model: each done pulse comes dly[k] negedges after its start is seen.
    initial begin
        rdone = '0;
        for (int k = 0; k < 4; k++) rcnt[k] = 0;
        forever begin
            logic [3:0] st;
            @(negedge clk);
            st = {bus.psum_start, bus.pe_start, bus.ifmap_start, bus.filt_start};
            for (int k = 0; k < 4; k++) begin
                if (reset) begin
                    rcnt[k]  = 0;
                    rdone[k] = 1'b0;
                end else begin
                    rdone[k] = 1'b0;
                    if (rcnt[k] > 0) begin
                        rcnt[k]--;
                        if (rcnt[k] == 0) rdone[k] = 1'b1;
                    end
                    if (st[k]) rcnt[k] = dly[k];
                end
            end
        end
    end

    // Monitor. It samples just after each rising edge. The inputs seen then are the
    // values the DUT sampled on that edge, so a pulse and its trigger show up together.
    initial begin
        int  kind;
        bit  prev_psum;
        bit  exp_busy_low;
        ev_t e;
        prev_psum    = 1'b0;
        exp_busy_low = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_psum    = 1'b0;
                exp_busy_low = 1'b0;
                continue;
            end
            if (exp_busy_low) begin
                chk("busy_drop_after_done", int'(busy), 0);
                exp_busy_low = 1'b0;
            end
            kind = 0;
            if (bus.filt_start)       kind = "F";
            else if (bus.ifmap_start) kind = "I";
            else if (bus.pe_start)    kind = "P";
            else if (bus.psum_start)  kind = "S";
            else if (done)            kind = "D";
            if (kind != 0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", kind, e.kind);
                    chk("pulse_pass", int'(pass_index), e.pass);
                    case (kind)
                        "F": chk("filt_trigger", int'(start | bus.psum_done), 1);
                        "I": chk("ifmap_trigger", int'(bus.filt_done | prev_psum), 1);
                        "P": chk("pe_trigger", int'(bus.ifmap_done), 1);
                        "S": chk("psum_trigger", int'(bus.pe_done), 1);
                        default: begin
                            chk("done_trigger", int'(bus.psum_done | start), 1);
                            chk("done_busy", int'(busy), 1);
                            exp_busy_low = 1'b1;
                        end
                    endcase
                end
            end
            prev_psum = bus.psum_done;
        end
    end

    task automatic launch(input int np, input int rr, input string s);
        push_str(s);
        num_passes = 8'(np);
        filt_reuse = 4'(rr);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) return;
        end
        chk("wait_idle_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_for(input int ph, input int ps);
        for (int i = 0; i < 500; i++) begin
            if (phase == 3'(ph) && pass_index == 8'(ps)) return;
            @(negedge clk);
        end
        chk("wait_phase_timeout", int'(phase), ph);
    endtask

    task automatic run_layer(input int np, input int rr, input string s);
        launch(np, rr, s);
        wait_idle();
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_phase"}, int'(phase), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_pass"}, int'(pass_index), 0);
        chk({nm, "_await"}, int'(bus.gen_await), 0);
        chk({nm, "_starts"}, int'({bus.filt_start, bus.ifmap_start, bus.pe_start, bus.psum_start}), 0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; num_passes = '0; filt_reuse = '0;
        glb_ready = 1'b0; stray_pe = 1'b0;
        for (int k = 0; k < 4; k++) dly[k] = 3;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b0;
        glb_ready = 1'b1;

        run_layer(1, 1, "FIPSD");
        chk("t1_pass_hold", int'(pass_index), 0);
        run_layer(3, 2, "FIPSIPSFIPSD");
        chk("t2_pass_hold", int'(pass_index), 2);
        run_layer(0, 3, "D");
        chk("t3_pass_hold", int'(pass_index), 0);
        run_layer(2, 0, "FIPSFIPSD");
        chk("t4_pass_hold", int'(pass_index), 1);

        // glb_ready stall: counted in IFMAP_WAIT, ignored in COMP
        dly[1] = 12; dly[2] = 12;
        launch(1, 1, "FIPSD");
        wait_for(2, 0);
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            glb_ready = 1'b0;
            #1;
            cnt += int'(bus.gen_await);
            chk("await_ifmap_phase", int'(phase), 2);
            @(negedge clk);
        end
        glb_ready = 1'b1;
        #1;
        chk("await_ifmap_count", cnt, 5);
        chk("await_release", int'(bus.gen_await), 0);
        wait_for(3, 0);
        for (int i = 0; i < 3; i++) begin
            glb_ready = 1'b0;
            #1;
            chk("await_comp", int'(bus.gen_await), 0);
            chk("await_comp_phase", int'(phase), 3);
            @(negedge clk);
        end
        glb_ready = 1'b1;
        wait_idle();
        dly[1] = 3; dly[2] = 3;

        // stray pe_done in FILT_WAIT and start while busy
        launch(2, 1, "FIPSFIPSD");
        wait_for(1, 0);
        @(negedge clk);
        stray_pe = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        stray_pe = 1'b0;
        start    = 1'b0;
        #1;
        chk("stray_phase", int'(phase), 1);
        wait_idle();
        chk("stray_pass_hold", int'(pass_index), 1);

        // reset in COMP_WAIT of pass 1
        launch(3, 1, "FIPSFIPSFIPSD");
        wait_for(3, 1);
        @(negedge clk);
        chk("pre_reset_phase", int'(phase), 3);
        glb_ready = 1'b0;
        reset     = 1'b1;
        #1;
        sb.delete();
        chk_quiet("midreset");
        repeat (2) @(negedge clk);
        chk_quiet("midreset_hold");
        reset     = 1'b0;
        glb_ready = 1'b1;
        run_layer(1, 1, "FIPSD");
        chk("after_reset_pass", int'(pass_index), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
